// File: rtl/psg_stereo_mixer.sv
// psg_stereo_mixer: time-multiplexed stereo mixer for one or two PSG chips
// (TurboSound), a beeper bit and an 8-bit covox sample. Each sample strobe
// snapshots the inputs and runs a fixed five-step accumulation pass that
// ends with one saturated 16-bit left/right sample pair and a VALID pulse.
module psg_stereo_mixer #(
    parameter logic [7:0] BEEP_LEVEL = 8'd255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SMP,
    input  logic [7:0]  A0,
    input  logic [7:0]  B0,
    input  logic [7:0]  C0,
    input  logic [7:0]  A1,
    input  logic [7:0]  B1,
    input  logic [7:0]  C1,
    input  logic        TS_EN,
    input  logic [1:0]  STEREO,
    input  logic        BEEPER,
    input  logic        BEEP_EN,
    input  logic [7:0]  COVOX,
    input  logic [1:0]  GAIN,
    output logic [15:0] OUT_L,
    output logic [15:0] OUT_R,
    output logic        VALID,
    output logic        BUSY,
    output logic        OVERRUN
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S_PSG0  = 3'd1,
        S_PSG1  = 3'd2,
        S_COVOX = 3'd3,
        S_BEEP  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    // One chip's panned contribution; each side is at most 765.
    typedef struct packed {
        logic [9:0] l;
        logic [9:0] r;
    } pan_t;

    // Panning: 00/11 ABC, 01 ACB, 10 mono.
    function automatic pan_t pan(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [1:0] mode);
        pan_t       p;
        logic [9:0] a10;
        logic [9:0] b10;
        logic [9:0] c10;
        a10 = {2'b00, a};
        b10 = {2'b00, b};
        c10 = {2'b00, c};
        unique case (mode)
            2'b01: begin
                p.l = (a10 << 1) + c10;
                p.r = (b10 << 1) + c10;
            end
            2'b10: begin
                p.l = a10 + b10 + c10;
                p.r = a10 + b10 + c10;
            end
            default: begin
                p.l = (a10 << 1) + b10;
                p.r = (c10 << 1) + b10;
            end
        endcase
        return p;
    endfunction

    // Shift by 5+gain at 19 bits (2040 << 8 still fits), then clamp to 16 bits.
    function automatic logic [15:0] scale_sat(input logic [11:0] acc, input logic [1:0] gain);
        logic [18:0] wide;
        wide = {7'd0, acc} << (4'd5 + {2'b00, gain});
        return (|wide[18:16]) ? 16'hFFFF : wide[15:0];
    endfunction

    state_t      state_q, state_d;
    logic [11:0] acc_l_q, acc_l_d;
    logic [11:0] acc_r_q, acc_r_d;
    logic [15:0] out_l_q, out_l_d;
    logic [15:0] out_r_q, out_r_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        snap_load;

    // Input snapshot taken at the accepted strobe.
    logic [7:0]  a0_q, b0_q, c0_q, a1_q, b1_q, c1_q, covox_q;
    logic        ts_en_q, beep_q;
    logic [1:0]  stereo_q, gain_q;

    pan_t        pan0, pan1;

    assign pan0 = pan(a0_q, b0_q, c0_q, stereo_q);
    assign pan1 = pan(a1_q, b1_q, c1_q, stereo_q);

    // Capture the inputs that the coming pass is computed from.
    // NOTE: the snapshot has no reset; it is always loaded before a pass reads it.
    always_ff @(posedge CLK) begin
        if (snap_load) begin
            a0_q     <= A0;
            b0_q     <= B0;
            c0_q     <= C0;
            a1_q     <= A1;
            b1_q     <= B1;
            c1_q     <= C1;
            ts_en_q  <= TS_EN;
            stereo_q <= STEREO;
            beep_q   <= BEEPER & BEEP_EN;
            covox_q  <= COVOX;
            gain_q   <= GAIN;
        end
    end

    // Sequencer, accumulators and output registers; reset wins over everything.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            out_l_q   <= out_l_d;
            out_r_q   <= out_r_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state and datapath: one accumulation step per state.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q | (SMP & (state_q != IDLE));
        snap_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (SMP) begin
                    snap_load = 1'b1;
                    acc_l_d   = '0;
                    acc_r_d   = '0;
                    state_d   = S_PSG0;
                end
            end
            S_PSG0: begin
                acc_l_d = acc_l_q + {2'b00, pan0.l};
                acc_r_d = acc_r_q + {2'b00, pan0.r};
                state_d = S_PSG1;
            end
            S_PSG1: begin
                if (ts_en_q) begin
                    acc_l_d = acc_l_q + {2'b00, pan1.l};
                    acc_r_d = acc_r_q + {2'b00, pan1.r};
                end
                state_d = S_COVOX;
            end
            S_COVOX: begin
                acc_l_d = acc_l_q + {4'h0, covox_q};
                acc_r_d = acc_r_q + {4'h0, covox_q};
                state_d = S_BEEP;
            end
            S_BEEP: begin
                if (beep_q) begin
                    acc_l_d = acc_l_q + {4'h0, BEEP_LEVEL};
                    acc_r_d = acc_r_q + {4'h0, BEEP_LEVEL};
                end
                // Register the scaled result now so it is already on the
                // outputs during S_OUT, together with VALID.
                out_l_d = scale_sat(acc_l_d, gain_q);
                out_r_d = scale_sat(acc_r_d, gain_q);
                valid_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign OUT_L   = out_l_q;
    assign OUT_R   = out_r_q;
    assign VALID   = valid_q;
    assign BUSY    = (state_q != IDLE);
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Directed bench for psg_stereo_mixer: hand-computed sample values, cycle
// timing of BUSY/VALID, snapshot behaviour, overrun and mid-pass reset.
module tb_psg_stereo_mixer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SMP;
    logic [7:0]  A0, B0, C0, A1, B1, C1, COVOX;
    logic        TS_EN, BEEPER, BEEP_EN;
    logic [1:0]  STEREO, GAIN;
    logic [15:0] OUT_L, OUT_R;
    logic        VALID, BUSY, OVERRUN;

    int n_checks = 0;
    int n_fail   = 0;

    psg_stereo_mixer #(.BEEP_LEVEL(8'd255)) dut (
        .CLK(CLK), .RESET(RESET), .SMP(SMP),
        .A0(A0), .B0(B0), .C0(C0), .A1(A1), .B1(B1), .C1(C1),
        .TS_EN(TS_EN), .STEREO(STEREO), .BEEPER(BEEPER), .BEEP_EN(BEEP_EN),
        .COVOX(COVOX), .GAIN(GAIN),
        .OUT_L(OUT_L), .OUT_R(OUT_R), .VALID(VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        A0 = 0; B0 = 0; C0 = 0; A1 = 0; B1 = 0; C1 = 0; COVOX = 0;
        TS_EN = 0; BEEPER = 0; BEEP_EN = 0; STEREO = 2'b00; GAIN = 2'd0;
    endtask

    // Called at the negedge of cycle T with SMP already driven high.
    // Walks T+1..T+6 sampling on negedges. extra_k drives a second SMP at
    // T+extra_k, chg_k changes A0 at T+chg_k, chain leaves SMP high at T+6.
    task automatic do_pass(input string tag, input logic [15:0] exp_l, input logic [15:0] exp_r,
                           input int extra_k, input int chg_k, input bit chain);
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            if (k <= 5) begin
                check({tag, " busy"}, BUSY, 1);
                check({tag, " valid"}, VALID, (k == 5) ? 1 : 0);
            end
            if (k == 5) begin
                check({tag, " out_l"}, OUT_L, exp_l);
                check({tag, " out_r"}, OUT_R, exp_r);
            end
            if (k == 6) begin
                check({tag, " idle busy"}, BUSY, 0);
                check({tag, " idle valid"}, VALID, 0);
                check({tag, " hold l"}, OUT_L, exp_l);
                check({tag, " hold r"}, OUT_R, exp_r);
            end
            SMP = (k == extra_k) || (k == 6 && chain);
            if (k == chg_k) A0 = 8'd255;
        end
    endtask

    initial begin
        RESET = 1'b1;
        SMP   = 1'b0;
        clear_inputs();
        repeat (3) @(negedge CLK);
        check("rst out_l", OUT_L, 0);
        check("rst out_r", OUT_R, 0);
        check("rst valid", VALID, 0);
        check("rst busy", BUSY, 0);
        check("rst overrun", OVERRUN, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // ABC, A0 only: L = 2*255 = 510 -> <<5 = 16320
        A0 = 8'd255; SMP = 1;
        do_pass("abc", 16'd16320, 16'd0, 0, 0, 0);

        // ACB: L = 2A+C = 510, R = 2B+C = 200 -> 16320 / 6400
        STEREO = 2'b01; B0 = 8'd100; SMP = 1;
        do_pass("acb", 16'd16320, 16'd6400, 0, 0, 0);

        // mono: 10+10+10 = 30 -> 960
        STEREO = 2'b10; A0 = 8'd10; B0 = 8'd10; C0 = 8'd10; SMP = 1;
        do_pass("mono", 16'd960, 16'd960, 0, 0, 0);

        // STEREO=11 behaves as ABC: L = 510+100 = 610 -> 19520, R = 100 -> 3200
        STEREO = 2'b11; A0 = 8'd255; B0 = 8'd100; C0 = 8'd0; SMP = 1;
        do_pass("st11", 16'd19520, 16'd3200, 0, 0, 0);

        // Full scale: 765+765+255+255 = 2040 -> 65280 at GAIN 0
        STEREO = 2'b00; A0 = 255; B0 = 255; C0 = 255; A1 = 255; B1 = 255; C1 = 255;
        TS_EN = 1; COVOX = 255; BEEPER = 1; BEEP_EN = 1; GAIN = 0; SMP = 1;
        do_pass("full g0", 16'd65280, 16'd65280, 0, 0, 0);
        GAIN = 1; SMP = 1;
        do_pass("full g1", 16'd65535, 16'd65535, 0, 0, 0);
        check("no overrun yet", OVERRUN, 0);

        // Independent per-side clamp: L = 400<<8 sat, R = 20<<8 = 5120
        clear_inputs(); A0 = 8'd200; C0 = 8'd10; GAIN = 2'd3; SMP = 1;
        do_pass("sat side", 16'd65535, 16'd5120, 0, 0, 0);

        // Beeper gated by BEEP_EN, then enabled: 255 -> 8160
        clear_inputs(); BEEPER = 1; SMP = 1;
        do_pass("beep off", 16'd0, 16'd0, 0, 0, 0);
        BEEP_EN = 1; SMP = 1;
        do_pass("beep on", 16'd8160, 16'd8160, 0, 0, 0);

        // Covox alone: 100 -> 3200
        clear_inputs(); COVOX = 8'd100; SMP = 1;
        do_pass("covox", 16'd3200, 16'd3200, 0, 0, 0);

        // PSG1 excluded when TS_EN=0
        clear_inputs(); A1 = 255; B1 = 255; C1 = 255; SMP = 1;
        do_pass("ts off", 16'd0, 16'd0, 0, 0, 0);

        // Snapshot: A0 raised at T+2 must not reach this pass; covox 1 -> 32
        clear_inputs(); COVOX = 8'd1; SMP = 1;
        do_pass("snapshot", 16'd32, 16'd32, 0, 2, 0);

        // Overrun: extra SMP at T+3, then SMP at T+6 accepted with new input
        clear_inputs(); A0 = 8'd1; SMP = 1;
        do_pass("ovr first", 16'd64, 16'd0, 3, 0, 1);
        A0 = 8'd2;
        do_pass("ovr second", 16'd128, 16'd0, 0, 0, 0);
        check("overrun sticky", OVERRUN, 1);

        // Reset at T+3 aborts the pass and clears outputs and OVERRUN
        clear_inputs(); A0 = 8'd50; SMP = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            SMP = 0;
            if (k == 3) RESET = 1;
        end
        @(negedge CLK);
        RESET = 0;
        for (int k = 0; k < 6; k++) begin
            check("abort valid", VALID, 0);
            @(negedge CLK);
        end
        check("abort out_l", OUT_L, 0);
        check("abort out_r", OUT_R, 0);
        check("abort overrun", OVERRUN, 0);
        check("abort busy", BUSY, 0);

        // Fresh pass after reset; SMP in S_OUT is ignored but sets OVERRUN
        SMP = 1;
        do_pass("post rst", 16'd3200, 16'd0, 5, 0, 0);
        check("overrun at s_out", OVERRUN, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psg_stereo_mixer.md
Name: psg_stereo_mixer

Overview:
- Downstream consumer of the PSG channel outputs: takes the three 8-bit log-scaled channel levels from up to two PSG instances (TurboSound pair), plus a beeper bit and an 8-bit covox sample.
- Produces one 16-bit unsigned left/right sample pair per sample strobe.
- Supports ABC/ACB/mono panning, a gain shift and output saturation.
- Uses one time-multiplexed accumulation pass per sample and feeds the DAC/serialiser stage.

Parameters:
- BEEP_LEVEL, 8'd255, value added to both sides when BEEPER=1 and beeper is enabled.

Ports:
- CLK      in   1   system clock
- RESET    in   1   synchronous reset, active-high; clock CLK
- SMP      in   1   sample strobe, one CLK wide; starts a mix pass
- A0,B0,C0 in   8   PSG 0 channel levels
- A1,B1,C1 in   8   PSG 1 channel levels
- TS_EN    in   1   1 = include PSG 1
- STEREO   in   2   00 ABC, 01 ACB, 10 mono, 11 treated as ABC
- BEEPER   in   1   beeper bit
- BEEP_EN  in   1   1 = include beeper
- COVOX    in   8   covox sample, added to both sides
- GAIN     in   2   left-shift add-on, 0..3
- OUT_L    out  16  left sample
- OUT_R    out  16  right sample
- VALID    out  1   one-cycle pulse when OUT_L/OUT_R are updated
- BUSY     out  1   high while a pass is in progress
- OVERRUN  out  1   sticky: SMP arrived while BUSY

Behaviour:
- Reset: OUT_L=OUT_R=0, VALID=0, BUSY=0, OVERRUN=0, FSM=IDLE, accumulators=0. Reset wins over every other event in the same cycle.
- FSM states: IDLE, S_PSG0, S_PSG1, S_COVOX, S_BEEP, S_OUT.
  - IDLE + SMP (cycle T):
    - snapshot all data and control inputs (A0..C1, TS_EN, STEREO, BEEPER, BEEP_EN, COVOX, GAIN) into registers;
    - clear ACC_L/ACC_R (12 bit);
    - BUSY=1 from T+1;
    - go to S_PSG0.
  - Each state advances unconditionally on the next CLK. The pass computes only from the snapshot; input changes after T are ignored until the next pass.
  - S_PSG0 (T+1): ACC += pan(A0,B0,C0).
  - S_PSG1 (T+2): ACC += TS_EN ? pan(A1,B1,C1) : 0.
  - S_COVOX (T+3): ACC_L += COVOX, ACC_R += COVOX.
  - S_BEEP (T+4): ACC += (BEEP_EN & BEEPER) ? BEEP_LEVEL : 0.
  - S_OUT (T+5):
    - OUT_x = min(ACC_x << (5+GAIN), 16'hFFFF), with the shift computed at 19 bits before the clamp;
    - VALID=1 for this cycle only;
    - BUSY=0 from T+6;
    - return to IDLE.
- Latency: SMP at T gives VALID at T+5. Maximum sample rate is one SMP per 6 CLK.
- pan() per chip, each side 10 bits, max 765:
  - ABC: L=2A+B, R=2C+B.
  - ACB: L=2A+C, R=2B+C.
  - mono: L=R=A+B+C.
- Width rule: ACC maximum is 765+765+255+255=2040, fits 12 bits, no wrap. With GAIN=0 the output maximum is 65280 and never saturates. GAIN>=1 can saturate; saturation is per side and independent.
- SMP while BUSY, including in the S_OUT cycle: ignored, pass unaffected, OVERRUN set to 1. It stays 1 until RESET.
- SMP in the cycle after S_OUT (IDLE again) is accepted normally.
- OUT_L/OUT_R hold their values between VALID pulses.
- Reset mid-pass: the pass is aborted, no VALID is issued, outputs go to 0, and the next SMP starts a fresh pass.

Test Plan:
- Reset, then SMP with A0=255, B0=C0=0, STEREO=00, TS_EN=0, COVOX=0, BEEP_EN=0, GAIN=0 -> VALID exactly 5 cycles after SMP, OUT_L=16320, OUT_R=0, BUSY high for cycles T+1..T+5.
- Same stimulus with STEREO=01 and B0=100 -> OUT_L=16320, OUT_R=6400. Then STEREO=10 with A0=B0=C0=10 -> OUT_L=OUT_R=960.
- All six channels=255, TS_EN=1, COVOX=255, BEEPER=1, BEEP_EN=1 -> GAIN=0: both outputs 65280; GAIN=1: both 65535 (saturated).
- TS_EN=0 with A1=B1=C1=255 and PSG0 all 0 -> OUT_L=OUT_R=0. Change A0 to 255 at T+2 -> output unchanged (snapshot).
- Second SMP at T+3 -> still one VALID at T+5, OVERRUN=1 and stays set. SMP at T+6 -> accepted, VALID at T+11.
- RESET asserted at T+3 of a pass -> no VALID, OUT_L=OUT_R=0, OVERRUN=0, BUSY=0. Next SMP completes a normal pass.
